proc_dispatch_ctrl: RTL and testbench
=====================================

Name: proc_dispatch_ctrl

Overview:
- Allocates free processors to incoming commands and records each cmd_id -> proc_id binding in the scoreboard.
- Each dispatch runs in sequence: accept command, pick the lowest free processor, write the scoreboard entry, wait for the scoreboard ack, then pulse start to that processor.
- Tracks per-processor busy state from done pulses.
- Sequences scoreboard flushes once all processors have drained.

Parameters:
PROC_COUNT, 4, number of processors; also the scoreboard depth
CMD_ID_W, 8, command id width
ACK_TIMEOUT, 16, max cycles in WAIT_ACK before the dispatch is aborted

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  command accepted on valid&ready
i_cmd_id  in  CMD_ID_W  command id
o_sb_write  out  1  scoreboard write strobe, 1-cycle pulse
o_sb_cmd_id  out  CMD_ID_W  scoreboard entry key
o_sb_proc_id  out  $clog2(PROC_COUNT)  scoreboard entry value
i_sb_ack  in  1  scoreboard write acknowledge
o_sb_flush  out  1  scoreboard flush strobe, 1-cycle pulse
o_proc_start  out  PROC_COUNT  one-hot start pulse
o_proc_cmd_id  out  CMD_ID_W  cmd id sent with the start pulse
i_proc_done  in  PROC_COUNT  per-processor completion pulse
i_flush  in  1  flush request pulse
o_busy  out  PROC_COUNT  processor busy mask
o_err  out  1  1-cycle pulse on ack timeout

Behaviour:
- Clocking and reset:
  - One clock, i_clk. Reset i_rst is asynchronous and active-high.
  - During reset: state=IDLE; all outputs 0, including o_cmd_ready; busy=0; flush_pending=0; timeout counter=0.
  - Reset mid-dispatch drops the reservation: no start pulse and no scoreboard write after release.
- free = ~busy & ~reserved. sel = lowest index with free=1 (priority encoder).
- IDLE:
  - o_cmd_ready = (|free) & ~flush_pending.
  - On valid&ready: latch i_cmd_id and sel, set reserved[sel], go to SB_WRITE.
  - Else if flush_pending & busy==0: go to FLUSH.
- SB_WRITE: o_sb_write=1 with latched cmd_id/proc_id; go to WAIT_ACK. An ack in this cycle is ignored.
- WAIT_ACK:
  - o_sb_cmd_id and o_sb_proc_id are held stable. The counter increments each cycle.
  - If i_sb_ack=1: go to ISSUE. Ack has priority over a same-cycle timeout.
  - Else if count==ACK_TIMEOUT-1: pulse o_err, clear reserved, return to IDLE.
- ISSUE: o_proc_start[proc_id]=1 and o_proc_cmd_id=latched id for one cycle; set busy[proc_id], clear reserved; go to IDLE.
- FLUSH: o_sb_flush=1 for one cycle; clear flush_pending; go to IDLE.
- Latency: accept at edge E0 -> o_sb_write in cycle 1 -> earliest ack in cycle 2 -> o_proc_start in cycle 3 -> o_cmd_ready can reassert in cycle 4. Throughput is at most 1 command per 4 cycles.
- Done handling:
  - i_proc_done[k] clears busy[k] in any state.
  - Done on a non-busy processor is ignored.
  - A done and a set of busy[k] in the same cycle resolve to set.
  - A freed processor becomes selectable the cycle after its done.
- Flush handling:
  - i_flush sets flush_pending in any state.
  - While pending, no new commands are accepted; in-flight dispatch completes normally.
  - FLUSH is entered only when busy==0 and state is IDLE.
  - A repeated i_flush while pending is absorbed.
- Full and empty: with all processors busy, o_cmd_ready=0. The command waits with valid held; no drop, no error.
- o_busy is registered and reflects the busy mask directly.

Test Plan:
- Reset, then 4 commands with ids 0..3 and ack 1 cycle after each write -> sb entries (0,0),(1,1),(2,2),(3,3); o_proc_start one-hot in order 0001,0010,0100,1000; o_busy=1111; o_cmd_ready=0.
- All busy, id 9 waiting; pulse i_proc_done=0100 -> o_cmd_ready next cycle; sb entry (9,2); o_proc_start=0100.
- Ack held low -> o_err pulses exactly 16 cycles after entering WAIT_ACK; no o_proc_start; o_busy unchanged; o_cmd_ready returns.
- i_flush with busy=0011 -> o_cmd_ready=0; after done=0011, o_sb_flush pulses once 2 cycles later; o_cmd_ready then returns to 1.
- Assert i_rst during WAIT_ACK -> all outputs 0 immediately; after release o_busy=0000 and no start pulse ever issues for the aborted id.
- Ack and timeout in the same cycle (ack at the 16th WAIT_ACK cycle) -> ISSUE taken, o_err stays 0.

Source files
------------

// File: rtl/proc_dispatch_ctrl.sv
// proc_dispatch_ctrl: binds incoming commands to the lowest free processor via a scoreboard handshake
//   i_cmd_valid/o_cmd_ready/i_cmd_id      : command intake
//   o_sb_write/o_sb_cmd_id/o_sb_proc_id   : scoreboard entry write, completed by i_sb_ack
//   o_sb_flush                            : scoreboard flush once all processors have drained
//   o_proc_start/o_proc_cmd_id            : one-hot start pulse with its command id
//   i_proc_done/o_busy                    : per-processor completion and busy mask
//   i_flush/o_err                         : flush request, ack timeout pulse
module proc_dispatch_ctrl #(
   parameter int PROC_COUNT  = 4,
   parameter int CMD_ID_W    = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic [CMD_ID_W-1:0]           i_cmd_id,
   output logic                          o_sb_write,
   output logic [CMD_ID_W-1:0]           o_sb_cmd_id,
   output logic [$clog2(PROC_COUNT)-1:0] o_sb_proc_id,
   input  logic                          i_sb_ack,
   output logic                          o_sb_flush,
   output logic [PROC_COUNT-1:0]         o_proc_start,
   output logic [CMD_ID_W-1:0]           o_proc_cmd_id,
   input  logic [PROC_COUNT-1:0]         i_proc_done,
   input  logic                          i_flush,
   output logic [PROC_COUNT-1:0]         o_busy,
   output logic                          o_err
);
   localparam int PW = $clog2(PROC_COUNT);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, SB_WRITE, WAIT_ACK, ISSUE, FLUSH} state_t;
   state_t state, state_nxt;
   logic [PROC_COUNT-1:0] busy, reserved, free, pid_oh;
   logic [CMD_ID_W-1:0] cmd_q;
   logic [PW-1:0] pid_q, sel;
   logic [CW-1:0] cnt;
   logic flush_pending, accept, timeout;
   assign free    = ~busy & ~reserved;
   assign pid_oh  = PROC_COUNT'(1) << pid_q;
   // ready is forced low while reset is asserted so every output reads 0 in reset
   assign o_cmd_ready = ~i_rst & (state == IDLE) & (|free) & ~flush_pending;
   assign accept  = i_cmd_valid & o_cmd_ready;
   // a same-cycle ack wins over the timeout
   assign timeout = (state == WAIT_ACK) & ~i_sb_ack & (cnt == CW'(ACK_TIMEOUT - 1));
   assign o_sb_write    = state == SB_WRITE;
   assign o_sb_cmd_id   = (state == SB_WRITE || state == WAIT_ACK) ? cmd_q : '0;
   assign o_sb_proc_id  = (state == SB_WRITE || state == WAIT_ACK) ? pid_q : '0;
   assign o_proc_start  = (state == ISSUE) ? pid_oh : '0;
   assign o_proc_cmd_id = (state == ISSUE) ? cmd_q : '0;
   assign o_sb_flush    = state == FLUSH;
   assign o_err         = timeout;
   assign o_busy        = busy;
   always_comb begin
      sel = '0;
      for (int k = PROC_COUNT - 1; k >= 0; k--)
         if (free[k]) sel = PW'(k);
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = accept ? SB_WRITE : (flush_pending && busy == '0) ? FLUSH : IDLE;
         SB_WRITE: state_nxt = WAIT_ACK;
         WAIT_ACK: state_nxt = i_sb_ack ? ISSUE : timeout ? IDLE : WAIT_ACK;
         ISSUE:    state_nxt = IDLE;
         FLUSH:    state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         busy          <= '0;
         reserved      <= '0;
         cmd_q         <= '0;
         pid_q         <= '0;
         cnt           <= '0;
         flush_pending <= 1'b0;
      end else begin
         state         <= state_nxt;
         // a start to processor k outranks a done for k in the same cycle
         busy          <= (busy & ~i_proc_done) | ((state == ISSUE) ? pid_oh : '0);
         reserved      <= accept ? PROC_COUNT'(1) << sel : (state == ISSUE || timeout) ? '0 : reserved;
         cmd_q         <= accept ? i_cmd_id : cmd_q;
         pid_q         <= accept ? sel : pid_q;
         cnt           <= (state == WAIT_ACK) ? cnt + 1'b1 : '0;
         flush_pending <= i_flush | (flush_pending & (state != FLUSH));
      end
   end
endmodule

// File: tb/tb_proc_dispatch_ctrl.sv
// tb_proc_dispatch_ctrl: directed checks of dispatch, done, timeout, flush and reset behaviour
module tb_proc_dispatch_ctrl;
   logic       clk = 0, rst = 1;
   logic       cmd_valid = 0, cmd_ready;
   logic [7:0] cmd_id = 0;
   logic       sb_write, sb_ack = 0, sb_flush, flush = 0, err;
   logic [7:0] sb_cmd_id, proc_cmd_id;
   logic [1:0] sb_proc_id;
   logic [3:0] proc_start, proc_done = 0, busy;
   int total = 0, bad = 0;

   proc_dispatch_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_id(cmd_id), .o_sb_write(sb_write), .o_sb_cmd_id(sb_cmd_id),
      .o_sb_proc_id(sb_proc_id), .i_sb_ack(sb_ack), .o_sb_flush(sb_flush),
      .o_proc_start(proc_start), .o_proc_cmd_id(proc_cmd_id), .i_proc_done(proc_done),
      .i_flush(flush), .o_busy(busy), .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_dispatch(input logic [7:0] id);
      cmd_valid = 1; cmd_id = id;
      cyc();
      cmd_valid = 0;
      cyc();
      sb_ack = 1;
      cyc();
      sb_ack = 0;
      cyc();
   endtask

   task automatic test_reset();
      cyc();
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
      total++; if (busy !== 4'b0000) begin bad++; $display("FAIL reset_busy: got %b want 0000", busy); end
      total++; if ({sb_write, sb_flush, err, proc_start} !== 7'b0) begin bad++; $display("FAIL reset_outs: got %b want 0", {sb_write, sb_flush, err, proc_start}); end
      rst = 0;
      #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d: got %b want 1", i, cmd_ready); end
         cmd_valid = 1; cmd_id = 8'(i);
         cyc();
         cmd_valid = 0;
         total++; if ({sb_write, sb_cmd_id, sb_proc_id} !== {1'b1, 8'(i), 2'(i)}) begin bad++; $display("FAIL fill_sb%0d: got %b/%h/%0d want 1/%h/%0d", i, sb_write, sb_cmd_id, sb_proc_id, i, i); end
         cyc();
         sb_ack = 1;
         cyc();
         sb_ack = 0;
         total++; if (proc_start !== 4'(1 << i) || proc_cmd_id !== 8'(i)) begin bad++; $display("FAIL fill_start%0d: got %b/%h want %b/%h", i, proc_start, proc_cmd_id, 4'(1 << i), i); end
         cyc();
      end
      total++; if (busy !== 4'b1111) begin bad++; $display("FAIL fill_busy: got %b want 1111", busy); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_full: got %b want 0", cmd_ready); end
   endtask

   task automatic test_done_wait();
      cmd_valid = 1; cmd_id = 8'h09;
      cyc();
      total++; if (cmd_ready !== 1'b0 || sb_write !== 1'b0) begin bad++; $display("FAIL wait_full: got %b/%b want 0/0", cmd_ready, sb_write); end
      proc_done = 4'b0100;
      cyc();
      proc_done = 0;
      total++; if (cmd_ready !== 1'b1 || busy !== 4'b1011) begin bad++; $display("FAIL wait_freed: got %b/%b want 1/1011", cmd_ready, busy); end
      cyc();
      cmd_valid = 0;
      total++; if ({sb_write, sb_cmd_id, sb_proc_id} !== {1'b1, 8'h09, 2'd2}) begin bad++; $display("FAIL wait_sb: got %b/%h/%0d want 1/09/2", sb_write, sb_cmd_id, sb_proc_id); end
      cyc();
      sb_ack = 1;
      cyc();
      sb_ack = 0;
      total++; if (proc_start !== 4'b0100 || proc_cmd_id !== 8'h09) begin bad++; $display("FAIL wait_start: got %b/%h want 0100/09", proc_start, proc_cmd_id); end
      cyc();
      total++; if (busy !== 4'b1111) begin bad++; $display("FAIL wait_busy: got %b want 1111", busy); end
   endtask

   task automatic test_timeout();
      proc_done = 4'b0001;
      cyc();
      proc_done = 0;
      cmd_valid = 1; cmd_id = 8'h05;
      cyc();
      cmd_valid = 0;
      cyc();
      for (int k = 1; k < 16; k++) begin
         total++; if (err !== 1'b0 || proc_start !== 4'b0) begin bad++; $display("FAIL to_early%0d: got %b/%b want 0/0000", k, err, proc_start); end
         cyc();
      end
      total++; if (err !== 1'b1 || sb_cmd_id !== 8'h05 || sb_proc_id !== 2'd0) begin bad++; $display("FAIL to_err: got %b/%h/%0d want 1/05/0", err, sb_cmd_id, sb_proc_id); end
      cyc();
      total++; if ({err, proc_start} !== 5'b0) begin bad++; $display("FAIL to_after: got %b want 0", {err, proc_start}); end
      total++; if (busy !== 4'b1110 || cmd_ready !== 1'b1) begin bad++; $display("FAIL to_state: got %b/%b want 1110/1", busy, cmd_ready); end
   endtask

   task automatic test_flush();
      proc_done = 4'b1100;
      cyc();
      proc_done = 0;
      run_dispatch(8'h07);
      total++; if (busy !== 4'b0011) begin bad++; $display("FAIL fl_setup: got %b want 0011", busy); end
      flush = 1;
      cyc();
      flush = 0;
      total++; if (cmd_ready !== 1'b0 || sb_flush !== 1'b0) begin bad++; $display("FAIL fl_block: got %b/%b want 0/0", cmd_ready, sb_flush); end
      flush = 1;
      cyc();
      flush = 0;
      proc_done = 4'b0011;
      cyc();
      proc_done = 0;
      total++; if (sb_flush !== 1'b0 || busy !== 4'b0000) begin bad++; $display("FAIL fl_d1: got %b/%b want 0/0000", sb_flush, busy); end
      cyc();
      total++; if (sb_flush !== 1'b1) begin bad++; $display("FAIL fl_pulse: got %b want 1", sb_flush); end
      cyc();
      total++; if (sb_flush !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL fl_done: got %b/%b want 0/1", sb_flush, cmd_ready); end
      cyc();
      total++; if (sb_flush !== 1'b0) begin bad++; $display("FAIL fl_once: got %b want 0", sb_flush); end
   endtask

   task automatic test_reset_mid();
      run_dispatch(8'h20);
      cmd_valid = 1; cmd_id = 8'h33;
      cyc();
      cmd_valid = 0;
      cyc();
      total++; if (sb_cmd_id !== 8'h33 || sb_proc_id !== 2'd1) begin bad++; $display("FAIL rm_wait: got %h/%0d want 33/1", sb_cmd_id, sb_proc_id); end
      rst = 1;
      #1;
      total++; if ({cmd_ready, sb_write, sb_cmd_id, sb_proc_id, sb_flush, proc_start, proc_cmd_id, busy, err} !== '0) begin bad++; $display("FAIL rm_zero: got %h want 0", {cmd_ready, sb_write, sb_cmd_id, sb_proc_id, sb_flush, proc_start, proc_cmd_id, busy, err}); end
      cyc();
      rst = 0;
      sb_ack = 1;
      for (int k = 0; k < 20; k++) begin
         total++; if (proc_start !== 4'b0 || sb_write !== 1'b0) begin bad++; $display("FAIL rm_nostart%0d: got %b/%b want 0000/0", k, proc_start, sb_write); end
         cyc();
      end
      sb_ack = 0;
      total++; if (busy !== 4'b0000 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_after: got %b/%b want 0000/1", busy, cmd_ready); end
   endtask

   task automatic test_ack_at_timeout();
      cmd_valid = 1; cmd_id = 8'h44;
      cyc();
      cmd_valid = 0;
      cyc();
      for (int k = 1; k < 16; k++) cyc();
      sb_ack = 1;
      #1;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL at_err: got %b want 0", err); end
      cyc();
      sb_ack = 0;
      total++; if (proc_start !== 4'b0001 || proc_cmd_id !== 8'h44) begin bad++; $display("FAIL at_start: got %b/%h want 0001/44", proc_start, proc_cmd_id); end
      cyc();
      total++; if (busy !== 4'b0001 || err !== 1'b0) begin bad++; $display("FAIL at_busy: got %b/%b want 0001/0", busy, err); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_done_wait();
      test_timeout();
      test_flush();
      test_reset_mid();
      test_ack_at_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
